// File: rtl/mul_share_scheduler.sv
// mul_share_scheduler
// Round-robin front end that time-shares one sequential signed multiplier
// between NREQ requesters. A granted requester's operands are latched,
// the multiplier is initialised for one cycle, the fixed iteration latency
// is counted out, and the product is returned tagged with the owner index.

module mul_share_scheduler #(
    parameter int W          = 16,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int MUL_CYCLES = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic                done,
    output logic [IDW-1:0]      done_id,
    output logic [2*W-1:0]      result,
    output logic [W-1:0]        mul_inA,
    output logic [W-1:0]        mul_inB,
    output logic                mul_init,
    input  logic [2*W-1:0]      mul_out
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [CW-1:0]   counter;

    logic            win_valid;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  rr_next;
    logic [IDW:0]    cand;

    // Round-robin search: first set req bit at or above rr_ptr, with wrap
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned n = 0; n < NREQ; n++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(n);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!win_valid && req[cand[IDW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
        rr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Grant is combinational so the accept pulse lands in the IDLE cycle
    // that samples the operands; suppressed while reset is held.
    always_comb begin
        gnt = '0;
        if (state == IDLE && !reset && win_valid)
            gnt[win_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    // Control FSM with registered multiplier drive and result outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            counter  <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            result   <= '0;
            mul_inA  <= '0;
            mul_inB  <= '0;
            mul_init <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (win_valid) begin
                        mul_inA  <= req_a[win_idx*W +: W];
                        mul_inB  <= req_b[win_idx*W +: W];
                        owner    <= win_idx;
                        rr_ptr   <= rr_next;
                        mul_init <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    mul_init <= 1'b0;
                    counter  <= CW'(MUL_CYCLES);
                    state    <= RUN;
                end
                RUN: begin
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) begin
                        result  <= mul_out;
                        done_id <= owner;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mul_init <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_scheduler.sv
// Testbench for mul_share_scheduler: a sequential multiplier stand-in whose
// output is only correct once its latency has elapsed, plus a timeline-based
// reference model (grant cycle -> init/done cycles) checked every cycle.

module tb_mul_share_scheduler;

    localparam int W          = 16;
    localparam int NREQ       = 4;
    localparam int IDW        = 2;
    localparam int MUL_CYCLES = 15;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic [2*W-1:0]      result;
    logic [W-1:0]        mul_inA;
    logic [W-1:0]        mul_inB;
    logic                mul_init;
    logic [2*W-1:0]      mul_out;

    int checks   = 0;
    int failures = 0;

    mul_share_scheduler #(
        .W          (W),
        .NREQ       (NREQ),
        .IDW        (IDW),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_a    (req_a),
        .req_b    (req_b),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .mul_inA  (mul_inA),
        .mul_inB  (mul_inB),
        .mul_init (mul_init),
        .mul_out  (mul_out)
    );

    always #5 clock = ~clock;

    // Multiplier stand-in: output is scrambled until MUL_CYCLES cycles after init
    logic signed [W-1:0] ma = '0;
    logic signed [W-1:0] mb = '0;
    int                  mcnt = 0;
    logic [2*W-1:0]      mprod;
    always @(posedge clock) begin
        if (mul_init) begin
            ma   <= mul_inA;
            mb   <= mul_inB;
            mcnt <= MUL_CYCLES - 1;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mprod   = (2*W)'(longint'(ma) * longint'(mb));
    assign mul_out = (mcnt == 0) ? mprod : (mprod ^ 32'h5A5A_0000 ^ 32'(mcnt));

    // Reference model state (timeline of the operation in flight)
    int             cyc;
    bit             m_active;
    int             m_g;
    int             m_done_cyc;
    int             m_done_at;
    int             m_owner;
    int             m_rr;
    logic [W-1:0]   m_inA;
    logic [W-1:0]   m_inB;
    logic [2*W-1:0] m_result;
    logic [IDW-1:0] m_done_id;
    logic [NREQ-1:0] last_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_g        = -10;
        m_done_cyc = -10;
        m_done_at  = -10;
        m_owner    = 0;
        m_rr       = 0;
        m_inA      = '0;
        m_inB      = '0;
        m_result   = '0;
        m_done_id  = '0;
        last_gnt   = '0;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock cycle: check grant before the edge, registered outputs after
    task automatic tick();
        logic [NREQ-1:0] eg;
        int              k;
        bit              idle;
        longint          pa;
        longint          pb;
        longint          pr;
        #1;
        idle = !m_active || (cyc >= m_done_cyc);
        eg   = '0;
        k    = -1;
        if (idle) begin
            for (int n = 0; n < NREQ; n++) begin
                int p;
                p = (m_rr + n) % NREQ;
                if (k < 0 && req[p]) k = p;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        last_gnt = eg;
        if (k >= 0) begin
            m_active   = 1'b1;
            m_g        = cyc;
            m_done_cyc = cyc + MUL_CYCLES + 2;
            m_owner    = k;
            m_inA      = req_a[k*W +: W];
            m_inB      = req_b[k*W +: W];
            m_rr       = (k + 1) % NREQ;
        end
        @(posedge clock);
        cyc++;
        #1;
        if (m_active && cyc == m_done_cyc) begin
            pa        = longint'($signed(m_inA));
            pb        = longint'($signed(m_inB));
            pr        = pa * pb;
            m_result  = pr[2*W-1:0];
            m_done_id = IDW'(m_owner);
            m_done_at = cyc;
        end
        chk("busy",     64'(busy),     64'(m_active && cyc < m_done_cyc));
        chk("mul_init", 64'(mul_init), 64'(m_active && cyc == m_g + 1));
        chk("done",     64'(done),     64'(cyc == m_done_at));
        chk("done_id",  64'(done_id),  64'(m_done_id));
        chk("result",   64'(result),   64'(m_result));
        chk("mul_inA",  64'(mul_inA),  64'(m_inA));
        chk("mul_inB",  64'(mul_inB),  64'(m_inB));
    endtask

    // Tick until done is seen, bounded; an expired bound is a failure
    task automatic run_until_done(input int max_ticks);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < max_ticks && !seen; t++) begin
            tick();
            seen = done;
        end
        chk("done_timeout", 64'(seen), 64'(1));
    endtask

    task automatic async_reset_check();
        reset = 1'b1;
        #1;
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_done",     64'(done),     64'(0));
        chk("rst_result",   64'(result),   64'(0));
        chk("rst_done_id",  64'(done_id),  64'(0));
        chk("rst_gnt",      64'(gnt),      64'(0));
        chk("rst_mul_init", 64'(mul_init), 64'(0));
        chk("rst_mul_inA",  64'(mul_inA),  64'(0));
        chk("rst_mul_inB",  64'(mul_inB),  64'(0));
        model_reset();
        @(posedge clock);
        cyc++;
        #1;
        reset = 1'b0;
    endtask

    logic [2*W-1:0] exp4 [4];

    initial begin
        cyc   = 0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        model_reset();

        // Power-on reset
        async_reset_check();
        tick();

        // Single request: -3 * 5
        set_op(0, 16'hFFFD, 16'd5);
        req = 4'b0001;
        tick();
        req = '0;
        run_until_done(MUL_CYCLES + 4);
        chk("single_result", 64'(result), 64'(32'hFFFF_FFF1));
        chk("single_id",     64'(done_id), 64'(0));

        // All four requesting continuously
        model_reset();
        async_reset_check();
        for (int i = 0; i < NREQ; i++)
            set_op(i, W'(i + 1), W'(-(i + 1)));
        exp4[0] = 32'hFFFF_FFFF;
        exp4[1] = 32'hFFFF_FFFC;
        exp4[2] = 32'hFFFF_FFF7;
        exp4[3] = 32'hFFFF_FFF0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            run_until_done(MUL_CYCLES + 4);
            chk("rr_result", 64'(result),  64'(exp4[i]));
            chk("rr_id",     64'(done_id), 64'(i));
        end
        tick();
        req = '0;
        run_until_done(MUL_CYCLES + 4);
        chk("rr_wrap_id", 64'(done_id), 64'(0));

        // Corner operands
        for (int c = 0; c < 3; c++) begin
            logic [W-1:0]   ca;
            logic [W-1:0]   cb;
            logic [2*W-1:0] ce;
            case (c)
                0:       begin ca = 16'h7FFF; cb = 16'h7FFF; ce = 32'h3FFF_0001; end
                1:       begin ca = 16'h8000; cb = 16'h8000; ce = 32'h4000_0000; end
                default: begin ca = 16'h8000; cb = 16'h0001; ce = 32'hFFFF_8000; end
            endcase
            set_op(3, ca, cb);
            req = 4'b1000;
            tick();
            req = '0;
            run_until_done(MUL_CYCLES + 4);
            chk("corner_result", 64'(result), 64'(ce));
        end

        // Withdrawal while busy: req[2] for one cycle
        set_op(0, 16'd11, 16'd13);
        set_op(2, 16'd99, 16'd99);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        req = 4'b0100;
        tick();
        req = '0;
        run_until_done(MUL_CYCLES + 4);
        chk("withdraw_result", 64'(result), 64'(32'd143));
        for (int t = 0; t < 5; t++) tick();

        // Reset in the middle of RUN, then a fresh operation
        set_op(0, 16'd100, 16'd3);
        req = 4'b0001;
        tick();
        req = '0;
        for (int t = 0; t < 8; t++) tick();
        async_reset_check();
        set_op(1, 16'd7, 16'hFFFA);
        req = 4'b0010;
        tick();
        req = '0;
        run_until_done(MUL_CYCLES + 4);
        chk("postrst_result", 64'(result),  64'(32'hFFFF_FFD6));
        chk("postrst_id",     64'(done_id), 64'(1));

        // Randomised traffic with legal requester behaviour
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (last_gnt[i] && $urandom_range(1, 0) == 0)
                        req[i] = 1'b0;
                    else if (!last_gnt[i] && $urandom_range(15, 0) == 0)
                        req[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    set_op(i, W'($urandom), W'($urandom));
                    req[i] = 1'b1;
                end
            end
            tick();
        end
        req = '0;
        for (int t = 0; t < MUL_CYCLES + 3; t++) tick();

        // Idle: nothing moves for 100 cycles
        for (int t = 0; t < 100; t++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
